// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel source: RGB565 colours, the bar palette, default geometry.
// Latency: none (package only).
// Backpressure: none (package only).
package vga_pkg;

  localparam int H_DISP_DEF = 640;
  localparam int V_DISP_DEF = 480;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Left-to-right colour of the eight vertical bars.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = RGB_WHITE;
      3'd1:    bar_color = RGB_YELLOW;
      3'd2:    bar_color = RGB_CYAN;
      3'd3:    bar_color = RGB_GREEN;
      3'd4:    bar_color = RGB_MAGENTA;
      3'd5:    bar_color = RGB_RED;
      3'd6:    bar_color = RGB_BLUE;
      default: bar_color = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/sprite_pos.sv
// One-axis bounce counter: moves the sprite origin by STEP per frame, reversing at 0 and LIMIT-SIZE.
// Latency: position updates on the clock edge where frame_end and move_en are both high.
// Backpressure: none; move_en=0 freezes position and direction.
module sprite_pos #(
  parameter int LIMIT = 640,
  parameter int SIZE  = 100,
  parameter int STEP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_end,
  input  logic        i_move_en,
  output logic [10:0] o_pos,
  output logic        o_dir
);

  localparam logic [10:0] MAX_POS = 11'(LIMIT - SIZE);
  localparam logic [10:0] STEP_W  = 11'(STEP);

  logic [10:0] r_pos;
  logic        r_dir;

  // Advance once per frame; clamp to the edge and reverse when the next step would reach or cross it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_dir <= 1'b1;
    end else if (i_frame_end && i_move_en) begin
      if (r_dir) begin
        if (r_pos + STEP_W >= MAX_POS) begin
          r_pos <= MAX_POS;
          r_dir <= 1'b0;
        end else begin
          r_pos <= r_pos + STEP_W;
        end
      end else begin
        if (r_pos <= STEP_W) begin
          r_pos <= '0;
          r_dir <= 1'b1;
        end else begin
          r_pos <= r_pos - STEP_W;
        end
      end
    end
  end

  assign o_pos = r_pos;
  assign o_dir = r_dir;

endmodule

// File: rtl/vga_pic_move.sv
// Pixel source: colour bars with a bouncing colour-keyed sprite read from an external sync ROM.
// Latency: pix_data valid one cycle after data_req; ROM address/strobe are combinational.
// Backpressure: none; accepts one request per clock.
module vga_pic_move
  import vga_pkg::*;
#(
  parameter int          H_DISP    = H_DISP_DEF,
  parameter int          V_DISP    = V_DISP_DEF,
  parameter int          IMG_W     = 100,
  parameter int          IMG_H     = 100,
  parameter int          STEP      = 2,
  parameter logic [15:0] KEY_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        move_en,
  output logic        rom_rd_en,
  output logic [13:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] pix_data
);

  localparam int BAR_W = H_DISP / 8;

  logic [10:0] w_x_pos, w_y_pos;
  logic        w_dir_x, w_dir_y;
  logic [10:0] w_x_off, w_y_off;
  logic        w_x_in, w_y_in, w_in_box;
  logic [13:0] w_addr;
  logic [2:0]  w_bar;
  logic        w_last_pix;

  logic        r_req, r_in_box, r_frame_end;
  logic [15:0] r_bg;

  sprite_pos #(.LIMIT(H_DISP), .SIZE(IMG_W), .STEP(STEP)) u_pos_x (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_frame_end (r_frame_end),
    .i_move_en   (move_en),
    .o_pos       (w_x_pos),
    .o_dir       (w_dir_x)
  );

  sprite_pos #(.LIMIT(V_DISP), .SIZE(IMG_H), .STEP(STEP)) u_pos_y (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_frame_end (r_frame_end),
    .i_move_en   (move_en),
    .o_pos       (w_y_pos),
    .o_dir       (w_dir_y)
  );

  // Offsets are only meaningful once the lower-bound guard holds, so the subtraction never wraps into a hit.
  assign w_x_off  = pix_x - w_x_pos;
  assign w_y_off  = pix_y - w_y_pos;
  assign w_x_in   = (pix_x >= w_x_pos) && (w_x_off < 11'(IMG_W));
  assign w_y_in   = (pix_y >= w_y_pos) && (w_y_off < 11'(IMG_H));
  assign w_in_box = data_req && w_x_in && w_y_in;
  assign w_addr   = 14'(w_y_off) * 14'(IMG_W) + 14'(w_x_off);

  assign rom_rd_en = w_in_box;
  assign rom_addr  = w_in_box ? w_addr : 14'd0;

  assign w_last_pix = data_req && (pix_x == 11'(H_DISP - 1)) && (pix_y == 11'(V_DISP - 1));

  // Bar index from a comparator chain against the bar boundaries, avoiding a divider.
  always_comb begin
    w_bar = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (pix_x < 11'((i + 1) * BAR_W)) w_bar = 3'(i);
    end
  end

  // Align request, hit flag and background with the ROM's one-cycle read latency; flag the frame's last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req       <= 1'b0;
      r_in_box    <= 1'b0;
      r_bg        <= '0;
      r_frame_end <= 1'b0;
    end else begin
      r_req       <= data_req;
      r_in_box    <= w_in_box;
      r_bg        <= bar_color(w_bar);
      r_frame_end <= w_last_pix;
    end
  end

  assign pix_data = r_req ? ((r_in_box && (rom_data != KEY_COLOR)) ? rom_data : r_bg) : 16'h0000;

endmodule

// File: tb/tb_vga_pic_move.sv
module tb_vga_pic_move;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_req = 1'b0;
  logic [10:0] pix_x = '0;
  logic [10:0] pix_y = '0;
  logic        move_en = 1'b1;
  logic        rom_rd_en;
  logic [13:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic [15:0] pix_data;

  int checks = 0;
  int failures = 0;

  vga_pic_move dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_req  (data_req),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .move_en   (move_en),
    .rom_rd_en (rom_rd_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_data  (pix_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] rom;
    logic        exp_rd;
    logic [13:0] exp_addr;
    logic [15:0] exp_pix;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Locate the sprite through the ROM port: origin hits address 0, far corner hits 9999, neighbours miss.
  task automatic probe(input string name, input int ex, input int ey);
    logic ok;
    @(negedge clk);
    ok = 1'b1;
    data_req = 1'b1;
    pix_x = 11'(ex); pix_y = 11'(ey); #1;
    ok &= (rom_rd_en === 1'b1) && (rom_addr === 14'd0);
    if (ex > 0) begin
      pix_x = 11'(ex - 1); pix_y = 11'(ey); #1;
      ok &= (rom_rd_en === 1'b0);
    end
    if (ey > 0) begin
      pix_x = 11'(ex); pix_y = 11'(ey - 1); #1;
      ok &= (rom_rd_en === 1'b0);
    end
    pix_x = 11'(ex + 99); pix_y = 11'(ey + 99); #1;
    ok &= (rom_rd_en === 1'b1) && (rom_addr === 14'd9999);
    data_req = 1'b0;
    chk(name, 32'(ok), 32'd1);
  endtask

  // Request the last pixel of the frame; move_en can differ between request and frame_end cycles.
  task automatic do_frame(input logic me_req, input logic me_fe);
    @(negedge clk);
    move_en = me_req;
    data_req = 1'b1;
    pix_x = 11'd639; pix_y = 11'd479;
    @(posedge clk); #1;
    data_req = 1'b0;
    move_en = me_fe;
    @(posedge clk); #1;
    move_en = me_req;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 11'd200, 11'd300, 16'hFFFF, 1'b0, 14'd0,    16'h07FF};
    vecs[1]  = '{1'b1, 11'd5,   11'd3,   16'hF81F, 1'b1, 14'd305,  16'hF81F};
    vecs[2]  = '{1'b1, 11'd5,   11'd3,   16'h0000, 1'b1, 14'd305,  16'hFFFF};
    vecs[3]  = '{1'b1, 11'd99,  11'd99,  16'h1234, 1'b1, 14'd9999, 16'h1234};
    vecs[4]  = '{1'b1, 11'd100, 11'd0,   16'h1234, 1'b0, 14'd0,    16'hFFE0};
    vecs[5]  = '{1'b1, 11'd0,   11'd100, 16'h1234, 1'b0, 14'd0,    16'hFFFF};
    vecs[6]  = '{1'b1, 11'd79,  11'd200, 16'h1234, 1'b0, 14'd0,    16'hFFFF};
    vecs[7]  = '{1'b1, 11'd80,  11'd200, 16'h1234, 1'b0, 14'd0,    16'hFFE0};
    vecs[8]  = '{1'b1, 11'd240, 11'd10,  16'h1234, 1'b0, 14'd0,    16'h07E0};
    vecs[9]  = '{1'b1, 11'd320, 11'd10,  16'h1234, 1'b0, 14'd0,    16'hF81F};
    vecs[10] = '{1'b1, 11'd400, 11'd10,  16'h1234, 1'b0, 14'd0,    16'hF800};
    vecs[11] = '{1'b1, 11'd480, 11'd10,  16'h1234, 1'b0, 14'd0,    16'h001F};
    vecs[12] = '{1'b1, 11'd639, 11'd10,  16'h1234, 1'b0, 14'd0,    16'h0000};
    vecs[13] = '{1'b0, 11'd5,   11'd3,   16'hF81F, 1'b0, 14'd0,    16'h0000};
    vecs[14] = '{1'b1, 11'd0,   11'd0,   16'hABCD, 1'b1, 14'd0,    16'hABCD};

    // Reset held while requests toggle outside the sprite area.
    rom_data = 16'hF81F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_req = ~data_req;
      pix_x = 11'd200; pix_y = 11'd300; #1;
      chk("reset_rd_en", 32'(rom_rd_en), 32'd0);
      @(posedge clk); #1;
      chk("reset_pix", 32'(pix_data), 32'd0);
    end
    @(negedge clk);
    data_req = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("reset_addr", 32'(rom_addr), 32'd0);
    probe("reset_pos", 0, 0);

    // Table-driven single-pixel requests with the sprite at the origin.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      data_req = vecs[i].req;
      pix_x = vecs[i].x; pix_y = vecs[i].y; #1;
      chk($sformatf("vec%0d_rd_en", i), 32'(rom_rd_en), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      @(posedge clk); #1;
      data_req = 1'b0;
      rom_data = vecs[i].rom; #1;
      chk($sformatf("vec%0d_pix", i), 32'(pix_data), 32'(vecs[i].exp_pix));
    end

    // Frozen for three frames, then one enabled frame steps both axes.
    for (int f = 0; f < 3; f++) do_frame(1'b0, 1'b0);
    probe("freeze_pos", 0, 0);
    do_frame(1'b1, 1'b1);
    probe("unfreeze_pos", 2, 2);

    // Run to the right edge; Y bounces off the bottom at 380 along the way.
    for (int f = 0; f < 268; f++) do_frame(1'b1, 1'b1);
    probe("pre_bounce_pos", 538, 222);
    do_frame(1'b1, 1'b1);
    probe("bounce_clamp_pos", 540, 220);
    do_frame(1'b1, 1'b1);
    probe("bounce_back_pos", 538, 218);

    // move_en drops exactly in the frame_end cycle: no movement.
    do_frame(1'b1, 1'b0);
    probe("fe_move_en_fall_pos", 538, 218);
    // move_en rises exactly in the frame_end cycle: movement.
    do_frame(1'b0, 1'b1);
    probe("fe_move_en_rise_pos", 536, 216);

    // Asynchronous reset mid-frame clears output and position immediately.
    @(negedge clk);
    data_req = 1'b1;
    pix_x = 11'd200; pix_y = 11'd300;
    @(posedge clk); #1;
    chk("pre_reset_pix", 32'(pix_data), 32'h07FF);
    #1 rst_n = 1'b0; #1;
    chk("async_reset_pix", 32'(pix_data), 32'd0);
    data_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    probe("post_reset_pos", 0, 0);
    @(posedge clk); #1;
    chk("post_reset_idle_pix", 32'(pix_data), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pic_move.md
# vga_pic_move

Pixel source that sits directly upstream of the VGA timing driver. On each `data_req` it turns the requested coordinate `pix_x`/`pix_y` into a 16-bit RGB565 pixel.
- The background is eight vertical colour bars.
- An IMG_W×IMG_H sprite is read from an external synchronous ROM and drawn over the bars. Pixels equal to a colour key are transparent.
- The sprite moves once per frame and bounces off the screen edges.

`pix_data` is valid one cycle after `data_req`, which is the cycle the driver samples it.

## Interface
Parameters:
- H_DISP, 640, active pixels per line
- V_DISP, 480, active lines per frame
- IMG_W, 100, sprite width in pixels
- IMG_H, 100, sprite height in pixels
- STEP, 2, pixels moved per frame on each axis
- KEY_COLOR, 16'h0000, sprite colour treated as transparent

Ports:
- clk  in  1  pixel clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- data_req  in  1  pixel request; next-cycle data wanted for `pix_x`/`pix_y`
- pix_x  in  11  requested column, 0..H_DISP-1, valid while `data_req`=1
- pix_y  in  11  requested row, 0..V_DISP-1, valid while `data_req`=1
- move_en  in  1  1 = sprite moves at frame end; 0 = sprite frozen
- rom_rd_en  out  1  ROM read strobe (combinational)
- rom_addr  out  14  ROM word address, row-major (combinational)
- rom_data  in  16  ROM read data, one-cycle latency after `rom_rd_en`
- pix_data  out  16  RGB565 pixel to the driver

## Operation
- **Hit test.** `in_box` = `data_req` && x_pos ≤ pix_x < x_pos+IMG_W && y_pos ≤ pix_y < y_pos+IMG_H.
- **ROM read.** `rom_rd_en` = `in_box`. `rom_addr` = (pix_y−y_pos)·IMG_W + (pix_x−x_pos) when `in_box`, else 0.
- **Background.** Bar index = pix_x / (H_DISP/8), found with a comparator chain, not a divider. `bg_r` is registered from an 8-entry palette: white, yellow, cyan, green, magenta, red, blue, black.
- **Pipeline registers.** `req_r`, `in_box_r` and `bg_r` are each registered from the cycle of `data_req`.
- **Output mux.** `pix_data` = `req_r` ? ((`in_box_r` && `rom_data`≠KEY_COLOR) ? `rom_data` : `bg_r`) : 0.
- **Frame end.** `frame_end` is a one-cycle pulse, registered, asserted the cycle after `data_req`=1 with pix_x=H_DISP−1 and pix_y=V_DISP−1.
- **Motion.** At `frame_end` with `move_en`=1, update X; Y updates identically using V_DISP/IMG_H:
  - dir_x=1 (right):
    - if x_pos+STEP ≥ H_DISP−IMG_W: x_pos ← H_DISP−IMG_W, dir_x ← 0
    - else x_pos ← x_pos+STEP
  - dir_x=0 (left):
    - if x_pos ≤ STEP: x_pos ← 0, dir_x ← 1
    - else x_pos ← x_pos−STEP
- **Frozen sprite.** With `move_en`=0, x_pos, y_pos, dir_x and dir_y hold.
- **Update placement.** Position only changes at `frame_end`, which falls in vertical blanking, so a frame is never torn.
- **Widths.** All coordinate arithmetic is 11-bit unsigned. Compare against pix_x−x_pos only after the x_pos ≤ pix_x guard, so there is no wrap-around.

## Timing
- Reset values:
  - pix_data = 0, rom_rd_en = 0, rom_addr = 0
  - req_r = 0, in_box_r = 0, bg_r = 0, frame_end = 0
  - x_pos = 0, y_pos = 0, dir_x = 1, dir_y = 1
- Latency: `data_req` at cycle t produces `pix_data` at t+1. There is no back-pressure.
- Throughput: one pixel per clock. `data_req` may stay high for the whole line.
- Reset mid-frame: all state is cleared asynchronously. Output is 0 until the first `data_req` after release.
- Simultaneous `frame_end` and `move_en` falling: the value of `move_en` in the `frame_end` cycle decides.

## Structure
- Package `vga_pkg`:
  - RGB565 colour constants and the 8-entry bar palette
  - default H_DISP/V_DISP
- Sub-module `sprite_pos`: one-axis bounce counter with parameters LIMIT, SIZE and STEP, instantiated twice (X and Y).

## Test plan
- **Reset:** hold rst_n=0 while `data_req` toggles → pix_data=0, x_pos=y_pos=0, rom_rd_en=0.
- **Background:** request (200,300) with the sprite at (0,0) → next cycle pix_data=16'h07FF (cyan, bar 2), rom_rd_en=0.
- **Sprite hit:** request (5,3) with the sprite at (0,0) → rom_rd_en=1, rom_addr=305; with rom_data=16'hF81F, next cycle pix_data=16'hF81F.
- **Colour key:** same hit with rom_data=16'h0000 → pix_data equals the bar colour (16'hFFFF, white, bar 0).
- **Bounce:** preset x_pos=538, dir_x=1, then `frame_end` → x_pos=540, dir_x=0; next `frame_end` → x_pos=538.
- **Freeze:** move_en=0 across 3 frames → x_pos and y_pos unchanged; raise move_en → the next `frame_end` moves +STEP on both axes.
